// File: rtl/mult_arbiter.sv
// mult_arbiter: two-requester arbiter sharing one 32x32 multiplier, with busy-handshake timeout.
// Build option: define RR_PRIORITY_EN for round-robin arbitration (default is fixed priority, requester 0 first).
module mult_arbiter #(
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic [1:0]  ack,
  output logic [1:0]  err,
  output logic [63:0] result,
  output logic        mult_start,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic        mult_busy,
  input  logic [63:0] mult_product,
  output logic        arb_busy
);

  localparam int CNT_W = (BUSY_TIMEOUT < 1) ? 1 : $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic             owner;
  logic             grant_id;
  logic [CNT_W-1:0] cnt;

  function automatic logic [1:0] onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

`ifdef RR_PRIORITY_EN
  logic rr_ptr;

  // The pointed-to requester wins if it is asking; otherwise the other one does.
  always_comb begin
    grant_id = rr_ptr;
    if (!req[rr_ptr]) grant_id = ~rr_ptr;
  end
`else
  always_comb grant_id = ~req[0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      cnt        <= '0;
      ack        <= '0;
      err        <= '0;
      mult_start <= 1'b0;
      arb_busy   <= 1'b0;
      result     <= '0;
      mult_a     <= '0;
      mult_b     <= '0;
`ifdef RR_PRIORITY_EN
      rr_ptr     <= 1'b0;
`endif
    end else begin
      ack <= '0;
      err <= '0;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            owner      <= grant_id;
            mult_a     <= grant_id ? a1 : a0;
            mult_b     <= grant_id ? b1 : b0;
            mult_start <= 1'b1;
            arb_busy   <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (mult_busy) begin
            state <= RUN;
          end else begin
            cnt <= cnt + CNT_W'(1);
            // Counter lands exactly on BUSY_TIMEOUT here, so it can never wrap.
            if (cnt == CNT_LAST) begin
              err        <= onehot(owner);
              mult_start <= 1'b0;
              arb_busy   <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        RUN: begin
          if (!mult_busy) begin
            result     <= mult_product;
            ack        <= onehot(owner);
            mult_start <= 1'b0;
            state      <= DONE;
          end
        end
        DONE: begin
          arb_busy <= 1'b0;
`ifdef RR_PRIORITY_EN
          rr_ptr   <= ~owner;
`endif
          state    <= IDLE;
        end
        default: begin
          mult_start <= 1'b0;
          arb_busy   <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter BUSY_TIMEOUT, default 15, max cycles waited in WAIT_BUSY for mult_busy to rise.
REQ-002 clk  input  1  single clock, rising-edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  2  per-requester request; held high with operands stable until ack or err.
REQ-005 a0, b0  input  32 each  requester 0 operands.
REQ-006 a1, b1  input  32 each  requester 1 operands.
REQ-007 ack  output  2  one-cycle pulse to the owning requester; result valid that cycle.
REQ-008 err  output  2  one-cycle pulse to the owning requester on multiplier timeout.
REQ-009 result  output  64  registered product of the last completed operation.
REQ-010 mult_start  output  1  start to the shared 32x32 multiplier.
REQ-011 mult_a, mult_b  output  32 each  latched operands to the multiplier.
REQ-012 mult_busy  input  1  multiplier busy indication.
REQ-013 mult_product  input  64  multiplier product register.
REQ-014 arb_busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, START, WAIT_BUSY, RUN, DONE.
REQ-016 IDLE: when req != 0, select winner, latch its operands into mult_a/mult_b, record owner, go START; else stay.
REQ-017 Winner with RR_PRIORITY_EN: requester pointed to by rr_ptr if requesting, else the other.
REQ-018 START: mult_start=1, clear timeout counter, go WAIT_BUSY.
REQ-019 mult_start held 1 continuously in START, WAIT_BUSY, RUN; 0 in IDLE and DONE.
REQ-020 WAIT_BUSY: if mult_busy=1 go RUN; else increment counter; when counter reaches BUSY_TIMEOUT, pulse err[owner] for one cycle, drop mult_start, go IDLE.
REQ-021 RUN: stay while mult_busy=1; on first cycle mult_busy=0, capture mult_product into result, go DONE.
REQ-022 DONE: ack[owner]=1 for exactly one cycle, toggle rr_ptr to the non-owner, go IDLE.
REQ-023 ack and err are one-hot or zero; never both set; never to a non-owner.
REQ-024 Latency: ack asserted exactly one cycle after the first RUN cycle with mult_busy=0.
REQ-025 Operands latched at grant; later changes or early req deassertion do not affect the operation or the issued ack.
REQ-026 req still high in the cycle after ack/err is treated as a new request in IDLE.
REQ-027 mult_a/mult_b hold their value outside active operations; result holds until the next capture.
REQ-028 Timeout counter width is clog2(BUSY_TIMEOUT+1); it never wraps.

Reset
REQ-029 reset asserted, at any time including mid-operation: state=IDLE, ack=0, err=0, mult_start=0, arb_busy=0, result=0, mult_a=0, mult_b=0, rr_ptr=0, counter=0, immediately, not waiting for clk.
REQ-030 No ack or err is issued for an operation aborted by reset.

Configuration
REQ-031 Macro RR_PRIORITY_EN defined: round-robin arbitration per REQ-017 and REQ-022.
REQ-032 RR_PRIORITY_EN undefined: fixed priority, requester 0 always wins ties; rr_ptr is absent; all other behaviour identical.

Verification
REQ-033 req=01, a0=3, b0=5, multiplier model busy 8 cycles -> mult_a=3, mult_b=5, ack=01 one cycle after busy falls, result=15.
REQ-034 With RR_PRIORITY_EN: req=11 held continuously, after reset -> grants in order 0,1,0,1; ack alternates 01,10; without it -> ack always 01.
REQ-035 a1=FFFFFFFF, b1=FFFFFFFF -> ack=10, result=FFFFFFFE00000001.
REQ-036 Multiplier model never raises busy -> err[owner] pulses exactly 16 cycles after the START cycle (BUSY_TIMEOUT=15), mult_start drops, FSM in IDLE, ack stays 0.
REQ-037 Reset asserted during RUN -> all outputs at reset values asynchronously, no ack; after release req=10 with a1=7, b1=6 -> ack=10, result=42.
REQ-038 Operands changed and req dropped the cycle after grant -> result uses the originally latched operands; ack still issued to the owner.
